// File: rtl/zeta_rom_arbiter_if.sv
// Requester-side bus of the zeta ROM arbiter: two read ports.
// Each port has a req/gnt handshake and a valid/ready response stream.
interface zeta_rom_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 12
);
    logic              rq0_req;
    logic [ADDR_W-1:0] rq0_addr;
    logic              rq0_gnt;
    logic              rq0_rvalid;
    logic [DATA_W-1:0] rq0_rdata;
    logic              rq0_rready;

    logic              rq1_req;
    logic [ADDR_W-1:0] rq1_addr;
    logic              rq1_gnt;
    logic              rq1_rvalid;
    logic [DATA_W-1:0] rq1_rdata;
    logic              rq1_rready;

    modport master (
        output rq0_req, rq0_addr, rq0_rready, rq1_req, rq1_addr, rq1_rready,
        input  rq0_gnt, rq0_rvalid, rq0_rdata, rq1_gnt, rq1_rvalid, rq1_rdata
    );

    modport slave (
        input  rq0_req, rq0_addr, rq0_rready, rq1_req, rq1_addr, rq1_rready,
        output rq0_gnt, rq0_rvalid, rq0_rdata, rq1_gnt, rq1_rvalid, rq1_rdata
    );
endinterface

// File: rtl/zeta_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle synchronous twiddle ROM between the
// NTT butterfly (port 0) and basemul (port 1); each port has a 2-deep response FIFO.
module zeta_rom_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    zeta_rom_arbiter_if.slave rq,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout
);
    localparam int unsigned NREQ  = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [DATA_W-1:0] mem [NREQ][DEPTH];
    logic [CNT_W-1:0]  cnt [NREQ];
    logic [NREQ-1:0]   rptr;
    logic [NREQ-1:0]   wptr;
    logic [NREQ-1:0]   inflight;
    logic              last_gnt;
    logic [ADDR_W-1:0] last_ad;

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   rready;
    logic [NREQ-1:0]   rvalid;
    logic [NREQ-1:0]   pop;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   gnt;
    logic [ADDR_W-1:0] sel_ad;

    assign req    = {rq.rq1_req, rq.rq0_req};
    assign rready = {rq.rq1_rready, rq.rq0_rready};

    // A port may be granted only if the reply is guaranteed a FIFO slot,
    // counting the slot freed by a pop in this same cycle.
    always_comb begin
        rvalid = '0;
        pop    = '0;
        elig   = '0;
        for (int n = 0; n < NREQ; n++) begin
            rvalid[n] = !reset && (cnt[n] != '0);
            pop[n]    = rvalid[n] && rready[n];
            elig[n]   = !reset && req[n] &&
                        ((SUM_W'(cnt[n]) + SUM_W'(inflight[n])) <
                         (SUM_W'(DEPTH) + SUM_W'(pop[n])));
        end
    end

    // On contention the port that did not win last time goes first.
    always_comb begin
        gnt = elig;
        if (&elig) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

    assign sel_ad    = gnt[1] ? rq.rq1_addr : rq.rq0_addr;
    assign rom_ce    = |gnt;
    assign rom_ad    = reset ? '0 : (rom_ce ? sel_ad : last_ad);
    assign rom_oce   = 1'b1;
    assign rom_reset = reset;

    assign rq.rq0_gnt    = gnt[0];
    assign rq.rq1_gnt    = gnt[1];
    assign rq.rq0_rvalid = rvalid[0];
    assign rq.rq1_rvalid = rvalid[1];
    assign rq.rq0_rdata  = rvalid[0] ? mem[0][rptr[0]] : '0;
    assign rq.rq1_rdata  = rvalid[1] ? mem[1][rptr[1]] : '0;

    // Arbitration history, in-flight tracking and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
            last_ad  <= '0;
            inflight <= '0;
            rptr     <= '0;
            wptr     <= '0;
            for (int n = 0; n < NREQ; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            inflight <= gnt;
            if (|gnt) begin
                last_gnt <= gnt[1];
                last_ad  <= sel_ad;
            end
            for (int n = 0; n < NREQ; n++) begin
                if (inflight[n]) begin
                    wptr[n] <= ~wptr[n];
                end
                if (pop[n]) begin
                    rptr[n] <= ~rptr[n];
                end
                cnt[n] <= cnt[n] + CNT_W'(inflight[n]) - CNT_W'(pop[n]);
            end
        end
    end

    // ROM data lands one cycle after its grant, into the granted port's FIFO.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NREQ; n++) begin
            if (!reset && inflight[n]) begin
                mem[n][wptr[n]] <= rom_dout;
            end
        end
    end
endmodule

// File: tb/tb_zeta_rom_arbiter.sv
// Bench for zeta_rom_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_zeta_rom_arbiter;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              rom_ce;
    logic              rom_oce;
    logic              rom_reset;
    logic [ADDR_W-1:0] rom_ad;
    logic [DATA_W-1:0] rom_dout;

    zeta_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    zeta_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rq        (bus),
        .rom_ce    (rom_ce),
        .rom_oce   (rom_oce),
        .rom_reset (rom_reset),
        .rom_ad    (rom_ad),
        .rom_dout  (rom_dout)
    );

    always #5 clk = ~clk;

    int zt [256];
    int lit28 [4] = '{'h001, 'h011, 'h121, 'h630};

    // Synchronous-read ROM holding 17^i mod 3329.
    always @(posedge clk) begin
        if (rom_reset) rom_dout <= '0;
        else if (rom_ce) rom_dout <= 12'(zt[rom_ad]);
    end

    int errs = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    bit g0, g1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents and reads still travelling through the ROM.
    int q0[$], q1[$], a0[$], a1[$];
    int m_last = 1;
    int m_last_ad = 0;
    bit ev0, ev1, ep0, ep1, ee0, ee1, eg0, eg1;
    int ed0, ed1, ead;

    always @(negedge clk) begin
        if (chk_on) begin
            ev0 = !reset && (q0.size() > 0);
            ev1 = !reset && (q1.size() > 0);
            ed0 = ev0 ? q0[0] : 0;
            ed1 = ev1 ? q1[0] : 0;
            ep0 = ev0 && bus.rq0_rready;
            ep1 = ev1 && bus.rq1_rready;
            ee0 = !reset && bus.rq0_req && (q0.size() + a0.size() - int'(ep0) < 2);
            ee1 = !reset && bus.rq1_req && (q1.size() + a1.size() - int'(ep1) < 2);
            eg0 = ee0 && (!ee1 || m_last == 1);
            eg1 = ee1 && !eg0;
            ead = reset ? 0 : (eg0 ? int'(bus.rq0_addr) : (eg1 ? int'(bus.rq1_addr) : m_last_ad));

            chk("rq0_gnt",    int'(bus.rq0_gnt),    int'(eg0));
            chk("rq1_gnt",    int'(bus.rq1_gnt),    int'(eg1));
            chk("rq0_rvalid", int'(bus.rq0_rvalid), int'(ev0));
            chk("rq1_rvalid", int'(bus.rq1_rvalid), int'(ev1));
            chk("rq0_rdata",  int'(bus.rq0_rdata),  ed0);
            chk("rq1_rdata",  int'(bus.rq1_rdata),  ed1);
            chk("rom_ce",     int'(rom_ce),         int'(eg0 || eg1));
            chk("rom_ad",     int'(rom_ad),         ead);
            chk("rom_oce",    int'(rom_oce),        1);
            chk("rom_reset",  int'(rom_reset),      int'(reset));

            if (reset) begin
                q0.delete(); q1.delete(); a0.delete(); a1.delete();
                m_last = 1;
                m_last_ad = 0;
            end else begin
                if (ep0) void'(q0.pop_front());
                if (ep1) void'(q1.pop_front());
                while (a0.size() > 0) q0.push_back(a0.pop_front());
                while (a1.size() > 0) q1.push_back(a1.pop_front());
                if (eg0) begin
                    a0.push_back(zt[bus.rq0_addr]);
                    m_last = 0;
                    m_last_ad = int'(bus.rq0_addr);
                end
                if (eg1) begin
                    a1.push_back(zt[bus.rq1_addr]);
                    m_last = 1;
                    m_last_ad = int'(bus.rq1_addr);
                end
            end
        end
    end

    task automatic mid();
        @(negedge clk);
        g0 = bus.rq0_gnt;
        g1 = bus.rq1_gnt;
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        if (g0) bus.rq0_addr = bus.rq0_addr + 8'd1;
        if (g1) bus.rq1_addr = bus.rq1_addr + 8'd1;
    endtask

    task automatic idle(input int n);
        bus.rq0_req = 1'b0;
        bus.rq1_req = 1'b0;
        bus.rq0_rready = 1'b1;
        bus.rq1_rready = 1'b1;
        repeat (n) begin mid(); fin(); end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.rq0_req = 1'b0;
        bus.rq1_req = 1'b0;
        repeat (n) begin
            mid();
            chk("rst_rom_ce", int'(rom_ce), 0);
            chk("rst_rom_ad", int'(rom_ad), 0);
            fin();
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n0, n1;
        bit seen;
        reset = 1'b1;
        bus.rq0_req = 1'b0; bus.rq0_addr = '0; bus.rq0_rready = 1'b0;
        bus.rq1_req = 1'b0; bus.rq1_addr = '0; bus.rq1_rready = 1'b0;
        g0 = 1'b0; g1 = 1'b0;
        zt[0] = 1;
        for (int i = 1; i < 256; i++) zt[i] = (zt[i-1] * 17) % 3329;

        @(posedge clk); #1;
        chk_on = 1'b1;
        do_reset(3);

        // rq0 alone, consecutive addresses 0..3
        bus.rq0_rready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.rq0_req  = (k < 4);
            bus.rq0_addr = 8'(k < 4 ? k : 0);
            mid();
            if (k < 4) chk("r28_gnt", int'(bus.rq0_gnt), 1);
            if (k >= 2) chk("r28_rdata", int'(bus.rq0_rdata), lit28[k-2]);
            fin();
        end

        // ready held on empty FIFOs
        bus.rq0_req = 1'b0;
        bus.rq1_req = 1'b0;
        bus.rq0_rready = 1'b1;
        bus.rq1_rready = 1'b1;
        repeat (4) begin
            mid();
            chk("r33_rvalid0", int'(bus.rq0_rvalid), 0);
            chk("r33_rvalid1", int'(bus.rq1_rvalid), 0);
            fin();
        end

        // both requesting continuously: strict alternation starting with rq0
        do_reset(2);
        bus.rq0_addr = 8'h10; bus.rq1_addr = 8'h80;
        bus.rq0_req = 1'b1; bus.rq1_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("r29_gnt0", int'(bus.rq0_gnt), int'(k % 2 == 0));
            chk("r29_gnt1", int'(bus.rq1_gnt), int'(k % 2 == 1));
            fin();
        end
        idle(4);

        // rq0 not draining: exactly two grants, then rq1 owns the ROM
        do_reset(2);
        bus.rq0_rready = 1'b0; bus.rq1_rready = 1'b1;
        bus.rq0_req = 1'b1; bus.rq1_req = 1'b1;
        n0 = 0;
        for (int k = 0; k < 10; k++) begin
            mid();
            n0 += int'(g0);
            if (k >= 4) begin
                chk("r30_gnt0_blocked", int'(bus.rq0_gnt), 0);
                chk("r30_gnt1_streams", int'(bus.rq1_gnt), 1);
            end
            fin();
        end
        chk("r30_rq0_grants", n0, 2);
        bus.rq0_rready = 1'b1;
        mid(); seen = g0; fin();
        mid(); seen = seen || g0; fin();
        chk("r30_resume", int'(seen), 1);
        idle(4);

        // full-table stream on rq1
        do_reset(2);
        bus.rq1_rready = 1'b1;
        n1 = 0;
        for (int k = 0; k < 258; k++) begin
            bus.rq1_req  = (k < 256);
            bus.rq1_addr = 8'(k < 256 ? k : 0);
            mid();
            if (k < 256) n1 += int'(g1);
            if (k == 256) chk("r31_rdata_fe", int'(bus.rq1_rdata), 'h973);
            if (k == 257) chk("r31_rdata_ff", int'(bus.rq1_rdata), 'h497);
            fin();
        end
        chk("r31_grants", n1, 256);
        idle(2);

        // reset right after a grant discards the read
        do_reset(2);
        bus.rq0_rready = 1'b1; bus.rq1_rready = 1'b1;
        bus.rq0_req = 1'b1; bus.rq0_addr = 8'h05;
        mid();
        chk("r32_gnt", int'(bus.rq0_gnt), 1);
        fin();
        bus.rq0_req = 1'b0;
        reset = 1'b1;
        mid(); fin();
        reset = 1'b0;
        repeat (4) begin
            mid();
            chk("r32_rvalid0", int'(bus.rq0_rvalid), 0);
            chk("r32_rvalid1", int'(bus.rq1_rvalid), 0);
            fin();
        end
        bus.rq0_req = 1'b1; bus.rq1_req = 1'b1;
        mid();
        chk("r32_first_contest", int'(bus.rq0_gnt), 1);
        fin();
        idle(3);

        // randomized traffic with address churn while waiting and rare resets
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (g0 || !bus.rq0_req) begin
                bus.rq0_req  = ($urandom_range(0, 3) != 0);
                bus.rq0_addr = 8'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                bus.rq0_addr = 8'($urandom);
            end
            if (g1 || !bus.rq1_req) begin
                bus.rq1_req  = ($urandom_range(0, 3) != 0);
                bus.rq1_addr = 8'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                bus.rq1_addr = 8'($urandom);
            end
            bus.rq0_rready = ($urandom_range(0, 2) != 0);
            bus.rq1_rready = ($urandom_range(0, 2) != 0);
            mid();
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle(6);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
